// File: rtl/mode_sequencer_pkg.sv
// Shared widths, mode codes, FSM state type and the CTR counter helper for the
// block-chaining sequencer.
package mode_sequencer_pkg;

    localparam int BLK_S   = 128;
    localparam int IV_BITS = 128;
    localparam int BYTE_S  = 8;

    localparam logic [2:0] MODE_ECB  = 3'd0;
    localparam logic [2:0] MODE_CBC  = 3'd1;
    localparam logic [2:0] MODE_CTR  = 3'd2;
    localparam logic [2:0] MODE_CFB  = 3'd3;
    localparam logic [2:0] MODE_PCBC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IN   = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_CORE = 3'd3,
        ST_OUT       = 3'd4
    } state_t;

    // Counter bytes are big-endian by byte index: iv[7:0] is the most significant
    // byte. Swap into a plain integer, add one, swap back.
    function automatic logic [IV_BITS-1:0] ctr_inc(input logic [IV_BITS-1:0] v);
        logic [IV_BITS-1:0] sw;
        logic [IV_BITS-1:0] res;
        for (int b = 0; b < IV_BITS / BYTE_S; b++) begin
            sw[b*BYTE_S +: BYTE_S] = v[(IV_BITS/BYTE_S-1-b)*BYTE_S +: BYTE_S];
        end
        sw = sw + 1'b1;
        for (int b = 0; b < IV_BITS / BYTE_S; b++) begin
            res[b*BYTE_S +: BYTE_S] = sw[(IV_BITS/BYTE_S-1-b)*BYTE_S +: BYTE_S];
        end
        return res;
    endfunction

endpackage

// File: rtl/mode_sequencer_chain.sv
// Combinational chaining math: core input, result block and next IV for the
// selected mode and direction.
module mode_sequencer_chain
    import mode_sequencer_pkg::*;
(
    input  logic [2:0]         mode,
    input  logic               encrypt,
    input  logic [BLK_S-1:0]   d,
    input  logic [IV_BITS-1:0] iv,
    input  logic [BLK_S-1:0]   r,
    output logic [BLK_S-1:0]   pre,
    output logic [BLK_S-1:0]   post,
    output logic [IV_BITS-1:0] iv_next,
    output logic               core_enc
);

    always_comb begin
        pre      = d;
        post     = r;
        iv_next  = iv;
        core_enc = encrypt;
        case (mode)
            MODE_CBC, MODE_PCBC: begin
                pre  = encrypt ? (d ^ iv) : d;
                post = encrypt ? r : (r ^ iv);
                if (mode == MODE_CBC) iv_next = encrypt ? r : d;
                else                  iv_next = d ^ post;
            end
            MODE_CTR: begin
                pre      = iv;
                post     = r ^ d;
                iv_next  = ctr_inc(iv);
                core_enc = 1'b1;
            end
            MODE_CFB: begin
                pre      = iv;
                post     = r ^ d;
                iv_next  = encrypt ? post : d;
                core_enc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mode_sequencer.sv
// Per-message chaining controller: takes a config, then streams blocks one at a
// time through the AES core with mode-specific pre/post chaining.
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int MODE_W  = 3,
    parameter int TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MODE_W-1:0]  cfg_mode,
    input  logic               cfg_encrypt,
    input  logic [IV_BITS-1:0] cfg_iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLK_S-1:0]   in_data,
    input  logic               in_last,
    output logic               core_start,
    output logic               core_encrypt,
    output logic [BLK_S-1:0]   core_in,
    input  logic               core_done,
    input  logic [BLK_S-1:0]   core_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLK_S-1:0]   out_data,
    output logic               out_last,
    output logic               err,
    output logic [2:0]         dbg_state
);

    // Every stream transfers on a cycle where valid and ready are both high at
    // posedge; ready never depends combinationally on valid.
    state_t             state;
    logic [2:0]         mode_q;
    logic               enc_q;
    logic [IV_BITS-1:0] iv_q;
    logic [BLK_S-1:0]   d_q;
    logic               last_q;
    logic [31:0]        cnt;

    logic [BLK_S-1:0]   d_sel;
    logic [BLK_S-1:0]   ch_pre;
    logic [BLK_S-1:0]   ch_post;
    logic [IV_BITS-1:0] ch_iv_next;
    logic               ch_core_enc;
    logic               mode_legal;

    assign dbg_state  = state;
    assign mode_legal = (cfg_mode <= MODE_W'(MODE_PCBC));
    // Pre-chain is evaluated on the incoming block; post-chain on the stored one.
    assign d_sel      = (state == ST_WAIT_IN) ? in_data : d_q;

    mode_sequencer_chain u_chain (
        .mode     (mode_q),
        .encrypt  (enc_q),
        .d        (d_sel),
        .iv       (iv_q),
        .r        (core_out),
        .pre      (ch_pre),
        .post     (ch_post),
        .iv_next  (ch_iv_next),
        .core_enc (ch_core_enc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cfg_ready    <= 1'b1;
            in_ready     <= 1'b0;
            core_start   <= 1'b0;
            core_encrypt <= 1'b0;
            core_in      <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            err          <= 1'b0;
            mode_q       <= '0;
            enc_q        <= 1'b0;
            iv_q         <= '0;
            d_q          <= '0;
            last_q       <= 1'b0;
            cnt          <= '0;
        end else begin
            core_start <= 1'b0;
            err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (mode_legal) begin
                            mode_q    <= cfg_mode[2:0];
                            enc_q     <= cfg_encrypt;
                            iv_q      <= cfg_iv;
                            cfg_ready <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= ST_WAIT_IN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        d_q          <= in_data;
                        last_q       <= in_last;
                        core_in      <= ch_pre;
                        core_encrypt <= ch_core_enc;
                        core_start   <= 1'b1;
                        in_ready     <= 1'b0;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    cnt   <= 32'd1;
                    state <= ST_WAIT_CORE;
                end
                ST_WAIT_CORE: begin
                    if (core_done) begin
                        out_data  <= ch_post;
                        out_last  <= last_q;
                        iv_q      <= ch_iv_next;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else if (TIMEOUT > 0 && cnt >= 32'(TIMEOUT - 1)) begin
                        // Abort so the error lands TIMEOUT cycles after core_start.
                        err       <= 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_q) begin
                            cfg_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ST_WAIT_IN;
                        end
                    end
                end
                default: begin
                    cfg_ready <= 1'b1;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
